// File: rtl/ddr_burst_port_pkg.sv
// Shared constants and types for the DDR burst port.
// Contents: request/beat geometry, MIG command codes, FSM state encoding,
// and the per-beat address step helper.
package ddr_burst_port_pkg;

    localparam int unsigned ADDR_W     = 31;
    localparam int unsigned BEAT_W     = 256;
    localparam int unsigned BEATS      = 3;
    localparam int unsigned DATA_W     = BEATS * BEAT_W;
    localparam int unsigned ADDR_STEP  = 8;
    localparam int unsigned BEAT_CNT_W = $clog2(BEATS);
    localparam int unsigned CMD_W      = 3;

    localparam logic [CMD_W-1:0] CMD_WRITE = 3'b000;
    localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR      = 2'd1,
        ST_RD_CMD  = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    // Address of the following beat; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_beat_addr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(ADDR_STEP);
    endfunction

endpackage

// File: rtl/ddr_burst_port_beat_assembler.sv
// Collects BEATS read beats from the MIG into one DATA_W word.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   collect_en      high while a read is in flight; beats outside are dropped
//   rd_data/_valid  MIG read data beat and its valid
//   r_data_out      assembled word, beat 0 in LSBs; holds until next completion
//   r_valid         one-cycle strobe when r_data_out updates
module ddr_burst_port_beat_assembler
    import ddr_burst_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              collect_en,
    input  logic [BEAT_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic [DATA_W-1:0] r_data_out,
    output logic              r_valid
);

    // Only the first BEATS-1 beats need buffering; the last goes straight to the output.
    localparam int unsigned BUF_W = DATA_W - BEAT_W;
    localparam logic [BEAT_CNT_W-1:0] LAST_SLOT = BEAT_CNT_W'(BEATS - 1);

    logic [BEAT_CNT_W-1:0] slot_q, slot_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;

    // Beats shift in from the top so the first beat ends up in the LSBs.
    always_comb begin
        slot_d  = slot_q;
        buf_d   = buf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (collect_en && rd_data_valid) begin
            if (slot_q == LAST_SLOT) begin
                slot_d  = '0;
                data_d  = {rd_data, buf_q};
                valid_d = 1'b1;
            end else begin
                slot_d = slot_q + BEAT_CNT_W'(1);
                buf_d  = {rd_data, buf_q[BUF_W-1:BEAT_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q  <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign r_data_out = data_q;
    assign r_valid    = valid_q;

endmodule

// File: rtl/ddr_burst_port.sv
// Memory-side responder: turns one 768-bit write or read request into three
// 256-bit MIG app_* transactions and returns assembled read data.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   phy_init_done              MIG calibration done; requests ignored until set
//   write_in/w_address_in/w_data_in   write request (1-cycle strobe)
//   read_in/r_address_in       read request (1-cycle strobe)
//   w_busy, r_busy             port unavailable
//   r_data_out, r_valid        assembled read data and 1-cycle strobe
//   app_*                      MIG user interface command/write/read channels
module ddr_burst_port
    import ddr_burst_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              phy_init_done,
    input  logic              write_in,
    input  logic [ADDR_W-1:0] w_address_in,
    input  logic [DATA_W-1:0] w_data_in,
    input  logic              read_in,
    input  logic [ADDR_W-1:0] r_address_in,
    output logic              w_busy,
    output logic              r_busy,
    output logic [DATA_W-1:0] r_data_out,
    output logic              r_valid,
    output logic              app_en,
    output logic [CMD_W-1:0]  app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [BEAT_W-1:0] app_wdf_data,
    input  logic              app_wdf_rdy,
    input  logic [BEAT_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
);

    localparam int unsigned WBUF_W = DATA_W - BEAT_W;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    state_e                state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [WBUF_W-1:0]     wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  app_en_q, app_en_d;
    logic [CMD_W-1:0]      app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0]     app_addr_q, app_addr_d;
    logic                  app_wdf_wren_q, app_wdf_wren_d;
    logic [BEAT_W-1:0]     app_wdf_data_q, app_wdf_data_d;

    logic cmd_acc, dat_acc, beat_done, accept_ok, collect_en, rd_done;

    // Command and data channels handshake independently; a write beat is
    // complete once each has either already been taken or is taken now.
    assign cmd_acc    = app_en_q && app_rdy;
    assign dat_acc    = app_wdf_wren_q && app_wdf_rdy;
    assign beat_done  = (!app_en_q || app_rdy) && (!app_wdf_wren_q || app_wdf_rdy);
    assign accept_ok  = phy_init_done && !busy_q;
    assign collect_en = (state_q == ST_RD_CMD) || (state_q == ST_RD_WAIT);

    // Next-state and output computation.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        rd_pending_d   = rd_pending_q;
        rd_addr_d      = rd_addr_q;
        wdata_d        = wdata_q;
        app_en_d       = app_en_q;
        app_cmd_d      = app_cmd_q;
        app_addr_d     = app_addr_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_wdf_data_d = app_wdf_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_ok && write_in) begin
                    state_d        = ST_WR;
                    beat_d         = '0;
                    app_en_d       = 1'b1;
                    app_cmd_d      = CMD_WRITE;
                    app_addr_d     = w_address_in;
                    app_wdf_wren_d = 1'b1;
                    app_wdf_data_d = w_data_in[BEAT_W-1:0];
                    wdata_d        = w_data_in[DATA_W-1:BEAT_W];
                    // Simultaneous read is parked and started after the write.
                    if (read_in) begin
                        rd_pending_d = 1'b1;
                        rd_addr_d    = r_address_in;
                    end
                end else if (accept_ok && read_in) begin
                    state_d    = ST_RD_CMD;
                    beat_d     = '0;
                    app_en_d   = 1'b1;
                    app_cmd_d  = CMD_READ;
                    app_addr_d = r_address_in;
                end
            end
            ST_WR: begin
                if (cmd_acc) app_en_d = 1'b0;
                if (dat_acc) app_wdf_wren_d = 1'b0;
                if (beat_done) begin
                    if (beat_q == LAST_BEAT) begin
                        if (rd_pending_q) begin
                            state_d      = ST_RD_CMD;
                            rd_pending_d = 1'b0;
                            beat_d       = '0;
                            app_en_d     = 1'b1;
                            app_cmd_d    = CMD_READ;
                            app_addr_d   = rd_addr_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d         = beat_q + BEAT_CNT_W'(1);
                        app_en_d       = 1'b1;
                        app_wdf_wren_d = 1'b1;
                        app_addr_d     = next_beat_addr(app_addr_q);
                        app_wdf_data_d = wdata_q[BEAT_W-1:0];
                        wdata_d        = wdata_q >> BEAT_W;
                    end
                end
            end
            ST_RD_CMD: begin
                if (cmd_acc) begin
                    if (beat_q == LAST_BEAT) begin
                        app_en_d = 1'b0;
                        state_d  = ST_RD_WAIT;
                    end else begin
                        beat_d     = beat_q + BEAT_CNT_W'(1);
                        app_addr_d = next_beat_addr(app_addr_q);
                    end
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Busy is registered from the next state so it rises the cycle after accept.
    assign busy_d = !phy_init_done || (state_d != ST_IDLE) || rd_pending_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            beat_q         <= '0;
            rd_pending_q   <= 1'b0;
            rd_addr_q      <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b1;
            app_en_q       <= 1'b0;
            app_cmd_q      <= CMD_WRITE;
            app_addr_q     <= '0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            rd_pending_q   <= rd_pending_d;
            rd_addr_q      <= rd_addr_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_data_q <= app_wdf_data_d;
        end
    end

    ddr_burst_port_beat_assembler u_beat_assembler (
        .clk           (clk),
        .reset         (reset),
        .collect_en    (collect_en),
        .rd_data       (app_rd_data),
        .rd_data_valid (app_rd_data_valid),
        .r_data_out    (r_data_out),
        .r_valid       (rd_done)
    );

    assign r_valid      = rd_done;
    assign w_busy       = busy_q;
    assign r_busy       = busy_q;
    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign app_wdf_data = app_wdf_data_q;

endmodule

// File: tb/tb_ddr_burst_port.sv
// Self-checking bench for ddr_burst_port: scoreboard queues hold expected MIG
// commands, write beats and assembled read words; scenario tasks add inline checks.
module tb_ddr_burst_port;
    import ddr_burst_port_pkg::*;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic              clk;
    logic              reset;
    logic              phy_init_done;
    logic              write_in;
    logic [ADDR_W-1:0] w_address_in;
    logic [DATA_W-1:0] w_data_in;
    logic              read_in;
    logic [ADDR_W-1:0] r_address_in;
    logic              w_busy;
    logic              r_busy;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              app_en;
    logic [CMD_W-1:0]  app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic [BEAT_W-1:0] app_wdf_data;
    logic              app_wdf_rdy;
    logic [BEAT_W-1:0] app_rd_data;
    logic              app_rd_data_valid;

    int checks = 0;
    int errors = 0;

    cmd_t              exp_cmd_q[$];
    logic [BEAT_W-1:0] exp_wd_q[$];
    logic [DATA_W-1:0] exp_rd_q[$];
    cmd_t              mon_cmd;
    logic [BEAT_W-1:0] mon_wd;
    logic [DATA_W-1:0] mon_rd;

    ddr_burst_port dut (
        .clk               (clk),
        .reset             (reset),
        .phy_init_done     (phy_init_done),
        .write_in          (write_in),
        .w_address_in      (w_address_in),
        .w_data_in         (w_data_in),
        .read_in           (read_in),
        .r_address_in      (r_address_in),
        .w_busy            (w_busy),
        .r_busy            (r_busy),
        .r_data_out        (r_data_out),
        .r_valid           (r_valid),
        .app_en            (app_en),
        .app_cmd           (app_cmd),
        .app_addr          (app_addr),
        .app_rdy           (app_rdy),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_end       (app_wdf_end),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_rdy       (app_wdf_rdy),
        .app_rd_data       (app_rd_data),
        .app_rd_data_valid (app_rd_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake/strobe seen mid-cycle is matched against the queues.
    always @(negedge clk) begin
        if (app_en === 1'b1 && app_rdy === 1'b1) begin
            checks++;
            if (exp_cmd_q.size() == 0) begin
                errors++;
                $display("FAIL app_cmd_unexpected: got cmd=%b addr=%h, required no command", app_cmd, app_addr);
            end else begin
                mon_cmd = exp_cmd_q.pop_front();
                if (app_cmd !== mon_cmd.cmd || app_addr !== mon_cmd.addr) begin
                    errors++;
                    $display("FAIL app_cmd: got cmd=%b addr=%h, required cmd=%b addr=%h",
                             app_cmd, app_addr, mon_cmd.cmd, mon_cmd.addr);
                end
            end
        end
        if (app_wdf_wren === 1'b1 && app_wdf_rdy === 1'b1) begin
            checks++;
            if (exp_wd_q.size() == 0) begin
                errors++;
                $display("FAIL app_wdf_unexpected: got data=%h, required no write data", app_wdf_data);
            end else begin
                mon_wd = exp_wd_q.pop_front();
                if (app_wdf_data !== mon_wd || app_wdf_end !== 1'b1) begin
                    errors++;
                    $display("FAIL app_wdf: got data=%h end=%b, required data=%h end=1",
                             app_wdf_data, app_wdf_end, mon_wd);
                end
            end
        end
        if (r_valid === 1'b1) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL r_valid_unexpected: got r_valid=1, required 0");
            end else begin
                mon_rd = exp_rd_q.pop_front();
                if (r_data_out !== mon_rd) begin
                    errors++;
                    $display("FAIL r_data_out: got %h, required %h", r_data_out, mon_rd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [BEAT_W-1:0] rnd_beat();
        logic [BEAT_W-1:0] v;
        for (int i = 0; i < BEAT_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_cmds(input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] a;
        a = base;
        for (int i = 0; i < BEATS; i++) begin
            exp_cmd_q.push_back('{cmd: cmd, addr: a});
            a = a + ADDR_W'(ADDR_STEP);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; phy_init_done = 1'b0; write_in = 1'b1; read_in = 1'b1;
        w_address_in = 31'h40; r_address_in = 31'h80;
        step(2);
        checks++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_app: got en=%b wren=%b end=%b, required 0 0 0", app_en, app_wdf_wren, app_wdf_end);
        end
        checks++;
        if (w_busy !== 1'b1 || r_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got w=%b r=%b, required 1 1", w_busy, r_busy);
        end
        checks++;
        if (r_valid !== 1'b0 || r_data_out !== '0 || app_addr !== '0 || app_cmd !== 3'b000 || app_wdf_data !== '0) begin
            errors++;
            $display("FAIL reset_regs: got r_valid=%b addr=%h cmd=%b, required 0 0 000 with zero data", r_valid, app_addr, app_cmd);
        end
        reset = 1'b1;
        step(3);
        checks++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || w_busy !== 1'b1 || r_busy !== 1'b1) begin
            errors++;
            $display("FAIL phy_low_ignore: got en=%b wren=%b busy=%b%b, required 0 0 11", app_en, app_wdf_wren, w_busy, r_busy);
        end
        write_in = 1'b0; read_in = 1'b0; phy_init_done = 1'b1;
        step(1);
        checks++;
        if (w_busy !== 1'b0 || r_busy !== 1'b0 || app_en !== 1'b0) begin
            errors++;
            $display("FAIL phy_up_idle: got busy=%b%b en=%b, required 00 0", w_busy, r_busy, app_en);
        end
    endtask

    task automatic test_write();
        int n;
        push_cmds(CMD_WRITE, 31'h100);
        exp_wd_q.push_back(256'hA); exp_wd_q.push_back(256'hB); exp_wd_q.push_back(256'hC);
        w_address_in = 31'h100; w_data_in = {256'hC, 256'hB, 256'hA}; write_in = 1'b1;
        step(1);
        write_in = 1'b0;
        checks++;
        if (w_busy !== 1'b1 || app_en !== 1'b1 || app_wdf_end !== 1'b1) begin
            errors++;
            $display("FAIL write_start: got busy=%b en=%b end=%b, required 1 1 1", w_busy, app_en, app_wdf_end);
        end
        n = 0;
        while (w_busy === 1'b1 && n < 20) begin step(1); n++; end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles, required 3", n);
        end
        checks++;
        if (exp_cmd_q.size() != 0 || exp_wd_q.size() != 0) begin
            errors++;
            $display("FAIL write_drain: got %0d cmds %0d beats left, required 0 0", exp_cmd_q.size(), exp_wd_q.size());
        end
    endtask

    task automatic test_write_stall();
        int n;
        int bad;
        logic [BEAT_W-1:0] d0, d1, d2;
        d0 = rnd_beat(); d1 = rnd_beat(); d2 = rnd_beat();
        push_cmds(CMD_WRITE, 31'h200);
        exp_wd_q.push_back(d0); exp_wd_q.push_back(d1); exp_wd_q.push_back(d2);
        w_address_in = 31'h200; w_data_in = {d2, d1, d0}; write_in = 1'b1;
        step(1);
        write_in = 1'b0;
        step(1);
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || app_addr !== 31'h208 || app_wdf_data !== d1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles, required 0", bad);
        end
        app_rdy = 1'b1;
        step(1);
        checks++;
        if (app_en !== 1'b0 || app_wdf_wren !== 1'b1) begin
            errors++;
            $display("FAIL stall_cmd_only: got en=%b wren=%b, required 0 1", app_en, app_wdf_wren);
        end
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        step(1);
        checks++;
        if (app_en !== 1'b1 || app_addr !== 31'h210 || app_wdf_data !== d2) begin
            errors++;
            $display("FAIL stall_advance: got en=%b addr=%h, required 1 00000210", app_en, app_addr);
        end
        app_rdy = 1'b1;
        n = 0;
        while (w_busy === 1'b1 && n < 20) begin step(1); n++; end
        checks++;
        if (n != 1 || exp_cmd_q.size() != 0 || exp_wd_q.size() != 0) begin
            errors++;
            $display("FAIL stall_finish: got %0d cycles %0d cmds left, required 1 0", n, exp_cmd_q.size());
        end
    endtask

    task automatic test_read_wrap();
        logic [BEAT_W-1:0] d0, d1, d2;
        d0 = rnd_beat(); d1 = rnd_beat(); d2 = rnd_beat();
        exp_cmd_q.push_back('{cmd: CMD_READ, addr: 31'h7FFF_FFF8});
        exp_cmd_q.push_back('{cmd: CMD_READ, addr: 31'h0000_0000});
        exp_cmd_q.push_back('{cmd: CMD_READ, addr: 31'h0000_0008});
        exp_rd_q.push_back({d2, d1, d0});
        r_address_in = 31'h7FFF_FFF8; read_in = 1'b1;
        step(1);
        read_in = 1'b0;
        step(3);
        checks++;
        if (app_en !== 1'b0 || r_busy !== 1'b1 || exp_cmd_q.size() != 0) begin
            errors++;
            $display("FAIL read_cmds: got en=%b busy=%b left=%0d, required 0 1 0", app_en, r_busy, exp_cmd_q.size());
        end
        app_rd_data = d0; app_rd_data_valid = 1'b1; step(1);
        app_rd_data = d1; step(1);
        app_rd_data_valid = 1'b0; step(1);
        checks++;
        if (r_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_early_valid: got r_valid=%b, required 0", r_valid);
        end
        app_rd_data = d2; app_rd_data_valid = 1'b1; step(1);
        app_rd_data_valid = 1'b0;
        checks++;
        if (r_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_valid: got r_valid=%b, required 1", r_valid);
        end
        step(1);
        checks++;
        if (r_valid !== 1'b0 || r_data_out !== {d2, d1, d0} || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_after: got r_valid=%b busy=%b, required 0 0 with held data", r_valid, r_busy);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [BEAT_W-1:0] rd [BEATS];
        logic [DATA_W-1:0] wd;
        wd = {rnd_beat(), rnd_beat(), rnd_beat()};
        for (int i = 0; i < BEATS; i++) rd[i] = rnd_beat();
        push_cmds(CMD_WRITE, 31'h300);
        for (int i = 0; i < BEATS; i++) exp_wd_q.push_back(wd[i*BEAT_W +: BEAT_W]);
        push_cmds(CMD_READ, 31'h400);
        exp_rd_q.push_back({rd[2], rd[1], rd[0]});
        w_address_in = 31'h300; w_data_in = wd; r_address_in = 31'h400;
        write_in = 1'b1; read_in = 1'b1;
        step(1);
        write_in = 1'b0; read_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            if (i >= 6) begin
                app_rd_data = rd[i-6]; app_rd_data_valid = 1'b1;
            end
            step(1);
            if (w_busy !== 1'b1 || r_busy !== 1'b1) bad++;
        end
        app_rd_data_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d idle cycles, required 0", bad);
        end
        checks++;
        if (r_valid !== 1'b1 || exp_cmd_q.size() != 0 || exp_wd_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: got r_valid=%b cmds left=%0d, required 1 0", r_valid, exp_cmd_q.size());
        end
        step(1);
        checks++;
        if (w_busy !== 1'b0 || r_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: got busy=%b%b, required 00", w_busy, r_busy);
        end
    endtask

    task automatic test_reset_mid_read();
        int bad;
        exp_cmd_q.push_back('{cmd: CMD_READ, addr: 31'h500});
        r_address_in = 31'h500; read_in = 1'b1;
        step(1);
        read_in = 1'b0;
        step(1);
        app_rdy = 1'b0; reset = 1'b0;
        step(1);
        checks++;
        if (app_en !== 1'b0 || app_addr !== '0 || app_cmd !== 3'b000 || w_busy !== 1'b1 || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got en=%b addr=%h cmd=%b busy=%b, required 0 0 000 1", app_en, app_addr, app_cmd, w_busy);
        end
        reset = 1'b1; app_rdy = 1'b1;
        step(1);
        bad = 0;
        app_rd_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            app_rd_data = rnd_beat();
            step(1);
            if (r_valid !== 1'b0 || app_en !== 1'b0) bad++;
        end
        app_rd_data_valid = 1'b0;
        step(1);
        checks++;
        if (bad != 0 || r_valid !== 1'b0 || w_busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_rd_data: got %0d bad cycles busy=%b, required 0 0", bad, w_busy);
        end
    endtask

    initial begin
        reset = 1'b0; phy_init_done = 1'b0;
        write_in = 1'b0; read_in = 1'b0;
        w_address_in = '0; w_data_in = '0; r_address_in = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data = '0; app_rd_data_valid = 1'b0;

        test_reset();
        test_write();
        test_write_stall();
        test_read_wrap();
        test_back_to_back();
        test_reset_mid_read();

        checks++;
        if (exp_cmd_q.size() != 0 || exp_wd_q.size() != 0 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d/%0d/%0d entries left, required 0/0/0",
                     exp_cmd_q.size(), exp_wd_q.size(), exp_rd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
